// File: rtl/xalu_ise_issue.sv
// Core-side issue stage for the custom-instruction ALU: classify, issue, await result, return to writeback.
// Latency: result at writeback 2 cycles after accept best case; trap for non-custom/disabled opcode 1 cycle after accept.
// Backpressure: dec_rdy only in IDLE; writeback outputs held while wb_rdy is low.
module xalu_ise_issue #(
  parameter logic [3:0] CUSTOM_EN = 4'b0001,
  parameter int         TIMEOUT   = 8
) (
  input  logic        ise_clk,
  input  logic        ise_rst,
  input  logic        dec_val,
  output logic        dec_rdy,
  input  logic [31:0] dec_instr,
  input  logic [31:0] dec_rs1,
  input  logic [31:0] dec_rs2,
  output logic        ise_val,
  output logic [5:0]  ise_fn,
  output logic [6:0]  ise_imm,
  output logic [31:0] ise_in1,
  output logic [31:0] ise_in2,
  input  logic        ise_oval,
  input  logic [31:0] ise_out,
  output logic        wb_val,
  input  logic        wb_rdy,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_trap,
  output logic [15:0] cnt_ops,
  output logic [15:0] cnt_trap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  tcnt;
  logic        is_custom;
  logic [1:0]  cidx;
  logic        legal;
  logic        timed_out;

  // Register-field bits not needed by this block (rs1/rs2 specifiers).
  logic        unused_instr;
  assign unused_instr = ^dec_instr[24:15];

  // Control outputs come straight from the state register.
  assign dec_rdy   = (state == IDLE);
  assign ise_val   = (state == ISSUE);
  assign wb_val    = (state == RESP);
  assign timed_out = (tcnt == TMAX);

  // Opcode classification: custom-0..3 and whether that slot is implemented.
  always_comb begin
    is_custom = 1'b0;
    cidx      = 2'd0;
    case (dec_instr[6:0])
      7'b0001011: begin is_custom = 1'b1; cidx = 2'd0; end
      7'b0101011: begin is_custom = 1'b1; cidx = 2'd1; end
      7'b1011011: begin is_custom = 1'b1; cidx = 2'd2; end
      7'b1111011: begin is_custom = 1'b1; cidx = 2'd3; end
      default:    begin is_custom = 1'b0; cidx = 2'd0; end
    endcase
    legal = is_custom && CUSTOM_EN[cidx];
  end

  // State register.
  always_ff @(posedge ise_clk) begin
    if (ise_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; ALU result in the last ISSUE cycle beats the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dec_val) state_nxt = legal ? ISSUE : RESP;
      ISSUE:   if (ise_oval || timed_out) state_nxt = RESP;
      RESP:    if (wb_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch request on accept, capture result or trap, count retirements.
  always_ff @(posedge ise_clk) begin
    if (ise_rst) begin
      ise_fn   <= '0;
      ise_imm  <= '0;
      ise_in1  <= '0;
      ise_in2  <= '0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_trap  <= 1'b0;
      tcnt     <= '0;
      cnt_ops  <= '0;
      cnt_trap <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dec_val) begin
            ise_fn  <= {1'b0, dec_instr[14:12], cidx};
            ise_imm <= dec_instr[31:25];
            ise_in1 <= dec_rs1;
            ise_in2 <= dec_rs2;
            wb_rd   <= dec_instr[11:7];
            wb_data <= '0;
            wb_trap <= ~legal;
            tcnt    <= '0;
          end
        end
        ISSUE: begin
          if (ise_oval) begin
            wb_data <= ise_out;
            wb_trap <= 1'b0;
          end else if (timed_out) begin
            wb_data <= '0;
            wb_trap <= 1'b1;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        RESP: begin
          if (wb_rdy) begin
            if (wb_trap) cnt_trap <= cnt_trap + 16'd1;
            else         cnt_ops  <= cnt_ops + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xalu_ise_issue.sv
// Directed bench for xalu_ise_issue with CUSTOM_EN=4'b0001, TIMEOUT=8.
// Each vector: accept one op, drive ALU response after k cycles, hold wb_rdy low, then retire.
// Reset during ISSUE and RESP are exercised by hand-written sequences.
module tb_xalu_ise_issue;

  logic        ise_clk = 1'b0;
  logic        ise_rst;
  logic        dec_val;
  logic        dec_rdy;
  logic [31:0] dec_instr, dec_rs1, dec_rs2;
  logic        ise_val;
  logic [5:0]  ise_fn;
  logic [6:0]  ise_imm;
  logic [31:0] ise_in1, ise_in2;
  logic        ise_oval;
  logic [31:0] ise_out;
  logic        wb_val, wb_rdy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_trap;
  logic [15:0] cnt_ops, cnt_trap;

  int total = 0;
  int bad   = 0;
  int m_ops = 0;
  int m_trap = 0;

  always #5 ise_clk = ~ise_clk;

  xalu_ise_issue #(.CUSTOM_EN(4'b0001), .TIMEOUT(8)) dut (
    .ise_clk(ise_clk), .ise_rst(ise_rst),
    .dec_val(dec_val), .dec_rdy(dec_rdy), .dec_instr(dec_instr),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .ise_val(ise_val), .ise_fn(ise_fn), .ise_imm(ise_imm),
    .ise_in1(ise_in1), .ise_in2(ise_in2),
    .ise_oval(ise_oval), .ise_out(ise_out),
    .wb_val(wb_val), .wb_rdy(wb_rdy), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_trap(wb_trap),
    .cnt_ops(cnt_ops), .cnt_trap(cnt_trap)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    int          k;         // cycle after accept when ise_oval pulses; 0 = never
    logic [31:0] alu_out;
    int          rdy_dly;   // cycles wb_rdy held low once wb_val is up
    int          exp_lat;   // accept -> wb_val, cycles
    int          exp_nise;  // cycles with ise_val high
    logic [5:0]  exp_fn;
    logic [6:0]  exp_imm;
    logic [31:0] exp_data;
    logic        exp_trap;
    logic [4:0]  exp_rd;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " dec_rdy"}, 32'(dec_rdy), 32'd1);
    chk({tag, " ise_val"}, 32'(ise_val), 32'd0);
    chk({tag, " wb_val"},  32'(wb_val),  32'd0);
    chk({tag, " wb_trap"}, 32'(wb_trap), 32'd0);
    chk({tag, " ise_fn"},  32'(ise_fn),  32'd0);
    chk({tag, " ise_imm"}, 32'(ise_imm), 32'd0);
    chk({tag, " ise_in1"}, ise_in1, 32'd0);
    chk({tag, " ise_in2"}, ise_in2, 32'd0);
    chk({tag, " wb_rd"},   32'(wb_rd),   32'd0);
    chk({tag, " wb_data"}, wb_data, 32'd0);
    chk({tag, " cnt_ops"}, 32'(cnt_ops), 32'd0);
    chk({tag, " cnt_trap"}, 32'(cnt_trap), 32'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    int nise;
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge ise_clk);
    chk({t, " dec_rdy pre"}, 32'(dec_rdy), 32'd1);
    dec_val   = 1'b1;
    dec_instr = v.instr;
    dec_rs1   = v.rs1;
    dec_rs2   = v.rs2;
    wb_rdy    = 1'b0;
    @(negedge ise_clk);
    dec_val = 1'b0;
    lat  = 0;
    nise = 0;
    for (int j = 1; j <= 40; j++) begin
      if (wb_val) begin
        lat = j;
        break;
      end
      if (ise_val) begin
        nise++;
        if (nise == 1) begin
          chk({t, " ise_fn"},  32'(ise_fn),  32'(v.exp_fn));
          chk({t, " ise_imm"}, 32'(ise_imm), 32'(v.exp_imm));
          chk({t, " ise_in1"}, ise_in1, v.rs1);
          chk({t, " ise_in2"}, ise_in2, v.rs2);
          chk({t, " dec_rdy issue"}, 32'(dec_rdy), 32'd0);
        end
      end
      ise_oval = (v.k != 0) && (j == v.k);
      ise_out  = v.alu_out;
      @(negedge ise_clk);
    end
    ise_oval = 1'b0;
    if (lat == 0) $display("FAIL %s wb_val timeout: got none want latency %0d", t, v.exp_lat);
    chk({t, " latency"},  32'(lat),  32'(v.exp_lat));
    chk({t, " ise_cycles"}, 32'(nise), 32'(v.exp_nise));
    chk({t, " wb_data"}, wb_data, v.exp_data);
    chk({t, " wb_trap"}, 32'(wb_trap), 32'(v.exp_trap));
    chk({t, " wb_rd"},   32'(wb_rd),   32'(v.exp_rd));
    for (int b = 0; b < v.rdy_dly; b++) begin
      @(negedge ise_clk);
      chk({t, " hold wb_val"},  32'(wb_val),  32'd1);
      chk({t, " hold wb_data"}, wb_data, v.exp_data);
      chk({t, " hold wb_trap"}, 32'(wb_trap), 32'(v.exp_trap));
      chk({t, " hold wb_rd"},   32'(wb_rd),   32'(v.exp_rd));
      chk({t, " hold dec_rdy"}, 32'(dec_rdy), 32'd0);
    end
    wb_rdy = 1'b1;
    @(negedge ise_clk);
    wb_rdy = 1'b0;
    if (v.exp_trap) m_trap++;
    else            m_ops++;
    chk({t, " post wb_val"},  32'(wb_val),  32'd0);
    chk({t, " post dec_rdy"}, 32'(dec_rdy), 32'd1);
    chk({t, " cnt_ops"},  32'(cnt_ops),  32'(m_ops));
    chk({t, " cnt_trap"}, 32'(cnt_trap), 32'(m_trap));
  endtask

  initial begin
    //         instr         rs1           rs2           k  alu_out       dly lat nise fn        imm     data          trap rd
    vecs[0] = '{32'h0000_000B, 32'h1234_5678, 32'h9ABC_DEF0, 1, 32'hDEAD_BEEF, 0, 2, 1, 6'b000000, 7'd0,   32'hDEAD_BEEF, 1'b0, 5'd0};
    vecs[1] = '{32'h0A00_2A8B, 32'h0000_0001, 32'h0000_0002, 3, 32'h1122_3344, 0, 4, 3, 6'b001000, 7'd5,   32'h1122_3344, 1'b0, 5'd21};
    vecs[2] = '{32'h0000_002B, 32'h0000_0003, 32'h0000_0004, 1, 32'hFFFF_FFFF, 0, 1, 0, 6'b000000, 7'd0,   32'h0,         1'b1, 5'd0};
    vecs[3] = '{32'h0000_0033, 32'h0000_0005, 32'h0000_0006, 0, 32'h0,         0, 1, 0, 6'b000000, 7'd0,   32'h0,         1'b1, 5'd0};
    vecs[4] = '{32'h0000_000B, 32'hAAAA_0000, 32'h0000_5555, 0, 32'h7777_7777, 0, 9, 8, 6'b000000, 7'd0,   32'h0,         1'b1, 5'd0};
    vecs[5] = '{32'h0000_000B, 32'h0BAD_F00D, 32'h0000_0000, 8, 32'hCAFE_F00D, 0, 9, 8, 6'b000000, 7'd0,   32'hCAFE_F00D, 1'b0, 5'd0};
    vecs[6] = '{32'h0000_0F8B, 32'h0101_0101, 32'h0202_0202, 2, 32'h5A5A_5A5A, 5, 3, 2, 6'b000000, 7'd0,   32'h5A5A_5A5A, 1'b0, 5'd31};
    vecs[7] = '{32'hFE00_718B, 32'hFFFF_FFFF, 32'h8000_0000, 1, 32'h0,         0, 2, 1, 6'b011100, 7'h7F,  32'h0,         1'b0, 5'd3};
    vecs[8] = '{32'h0000_005B, 32'h0000_0000, 32'h0000_0000, 0, 32'h0,         2, 1, 0, 6'b000000, 7'd0,   32'h0,         1'b1, 5'd0};
    vecs[9] = '{32'h0000_00FB, 32'h0000_0000, 32'h0000_0000, 0, 32'h0,         0, 1, 0, 6'b000000, 7'd0,   32'h0,         1'b1, 5'd1};

    ise_rst   = 1'b1;
    dec_val   = 1'b0;
    dec_instr = '0;
    dec_rs1   = '0;
    dec_rs2   = '0;
    ise_oval  = 1'b0;
    ise_out   = '0;
    wb_rdy    = 1'b0;
    repeat (2) @(negedge ise_clk);
    ise_rst = 1'b0;
    chk_idle_zero("reset");

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Reset while waiting on the ALU: op dropped, everything back to zero.
    @(negedge ise_clk);
    dec_val   = 1'b1;
    dec_instr = 32'h0000_008B;
    dec_rs1   = 32'h1111_1111;
    dec_rs2   = 32'h2222_2222;
    @(negedge ise_clk);
    dec_val = 1'b0;
    repeat (2) @(negedge ise_clk);
    chk("rst_issue ise_val before", 32'(ise_val), 32'd1);
    ise_rst = 1'b1;
    @(negedge ise_clk);
    ise_rst = 1'b0;
    m_ops  = 0;
    m_trap = 0;
    chk_idle_zero("rst_issue");

    // Reset while writeback is stalled.
    dec_val   = 1'b1;
    dec_instr = 32'h0000_0033;
    @(negedge ise_clk);
    dec_val = 1'b0;
    chk("rst_resp wb_val before", 32'(wb_val), 32'd1);
    @(negedge ise_clk);
    ise_rst = 1'b1;
    @(negedge ise_clk);
    ise_rst = 1'b0;
    chk_idle_zero("rst_resp");

    // Normal op after reset.
    run_vec(10, vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xalu_ise_issue.md
# xalu_ise_issue

Core-side initiator for the custom-instruction ALU port. Accepts one decoded instruction with its register operands from the core pipeline, classifies it as custom-0..3, drives a registered request (ise_val, ise_fn, ise_imm, ise_in1, ise_in2) to the ISE ALU, and waits for ise_oval. Returns the captured result, or an illegal-instruction trap, to writeback through a valid/ready handshake. Sits between the core decode/operand-fetch stage and the ISE ALU.

## Interface
- CUSTOM_EN, 4'b0001: bit i set = custom-i opcode is implemented in the ALU; clear = trap without issuing.
- TIMEOUT, 8: cycles in ISSUE without ise_oval before trapping; legal 1..255.
- Clock is ise_clk; reset is ise_rst, synchronous, active-high.
- ise_clk  in  1  clock
- ise_rst  in  1  synchronous active-high reset
- dec_val  in  1  instruction and operands valid
- dec_rdy  out  1  block accepts instruction
- dec_instr  in  32  RV32 instruction word
- dec_rs1  in  32  rs1 value
- dec_rs2  in  32  rs2 value
- ise_val  out  1  request valid to ALU
- ise_fn  out  6  {1'b0, funct3, custom index}
- ise_imm  out  7  funct7 = instr[31:25]
- ise_in1  out  32  latched rs1
- ise_in2  out  32  latched rs2
- ise_oval  in  1  ALU result valid
- ise_out  in  32  ALU result
- wb_val  out  1  result valid
- wb_rdy  in  1  writeback accepts
- wb_rd  out  5  destination = instr[11:7]
- wb_data  out  32  result; 0 on trap
- wb_trap  out  1  illegal instruction
- cnt_ops  out  16  count of completed non-trap ops
- cnt_trap  out  16  count of trapped ops

## Operation
- Opcode classification on instr[6:0]: 0001011 = custom-0, 0101011 = custom-1, 1011011 = custom-2, 1111011 = custom-3; anything else = not custom.
- FSM states: IDLE, ISSUE, RESP.
- IDLE: dec_rdy=1. On dec_val: latch instr fields and operands. If custom-i with CUSTOM_EN[i]=1 go ISSUE, clear timeout counter. Otherwise go RESP with wb_trap=1, wb_data=0.
- ISSUE: ise_val=1, request outputs stable. If ise_oval: capture ise_out into wb_data, wb_trap=0, go RESP. Else increment timeout counter; when count reaches TIMEOUT-1 with no ise_oval, go RESP with wb_trap=1, wb_data=0. ise_oval outside ISSUE is ignored.
- RESP: wb_val=1; wb_rd/wb_data/wb_trap held. On wb_rdy: increment cnt_ops (trap=0) or cnt_trap (trap=1), go IDLE.
- Counters are 16-bit and wrap 0xFFFF -> 0x0000.
- Reset (any state, including mid-ISSUE or RESP): state IDLE; dec_rdy=1 the following cycle; ise_val, wb_val, wb_trap=0; ise_fn, ise_imm, ise_in1, ise_in2, wb_rd, wb_data=0; both counters 0. Any in-flight op is dropped with no response.

## Timing
- All outputs are registered or decoded from state only; no combinational path from ise_oval/ise_out or wb_rdy to any output.
- Accept at cycle T (dec_val&&dec_rdy) -> ise_val=1 at T+1 -> ise_oval sampled at T+1 -> wb_val=1 at T+2. Best-case latency 2 cycles; best-case throughput one op per 3 cycles (IDLE cycle required between ops).
- Multi-cycle ALU: ise_oval first seen at T+k (k ≤ TIMEOUT) -> wb_val at T+k+1.
- Timeout: no ise_oval in cycles T+1..T+TIMEOUT -> wb_val with trap at T+TIMEOUT+1. ise_oval in the final ISSUE cycle wins over timeout.
- Disabled or non-custom opcode: wb_val with trap at T+1; ise_val never asserts.
- Backpressure: wb_val, wb_rd, wb_data, wb_trap held unchanged while wb_rdy=0; dec_rdy stays 0.

## Test plan
- Reset then custom-0 instr 0x0000_000B, rs1=0x1234_5678, rs2=0x9ABC_DEF0, ALU returns oval same cycle with 0xDEAD_BEEF -> ise_val at T+1 with ise_fn=6'b000000, ise_imm=0; wb_val at T+2, wb_data=0xDEAD_BEEF, wb_trap=0, cnt_ops=1.
- Instr 0x0A00_2A8B (funct7=5, funct3=2, rd=21), ALU oval delayed 3 cycles -> ise_fn=6'b001000, ise_imm=7'd5; wb_val at T+4, wb_rd=21.
- Custom-1 opcode 0x2B with CUSTOM_EN=4'b0001 and opcode 0x33 -> no ise_val; wb_val at T+1, wb_trap=1, wb_data=0; cnt_trap increments to 2.
- ALU never asserts oval, TIMEOUT=8 -> ise_val high T+1..T+8, wb_trap=1 at T+9; oval at T+8 instead -> normal result.
- wb_rdy held low 5 cycles -> wb outputs stable, dec_rdy=0 throughout; accept on 6th cycle, dec_rdy=1 next cycle.
- ise_rst asserted during ISSUE and during RESP -> next cycle all outputs 0, dec_rdy=1, counters 0; next op completes normally.
